tt_capture_seq: RTL and testbench
=================================

TT_CAPTURE_SEQ -- requirements
Module: tt_capture_seq

Interface
REQ-001 SHALL have parameter SETTLE, default 1, giving cycles x is held stable before f is sampled (legal range 0..15).
REQ-002 SHALL have parameter NI, default 3, giving DUT input count; NO, default 6, giving DUT output count.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request one exhaustive sweep.
REQ-006 busy  output  1  high while a sweep is in progress.
REQ-007 done  output  1  one-cycle pulse when the sweep completes.
REQ-008 x  output  NI  vector driven onto the upstream combinational block's inputs (x[0]=x0).
REQ-009 f  input  NO  that block's outputs (f[0]=f1).
REQ-010 tt  output  (1<<NI)*NO  captured truth table.
REQ-011 sig  output  16  MISR signature; present only with TT_MISR_EN.

Function
REQ-012 SHALL implement FSM IDLE, APPLY, SAMPLE, DONE.
REQ-013 IDLE: x=0, busy=0; start=1 -> clear tt, idx=0, wait counter=0, go APPLY.
REQ-014 APPLY: x=idx, busy=1; after SETTLE cycles in APPLY go SAMPLE (SETTLE=0 -> straight to SAMPLE next cycle).
REQ-015 SAMPLE: x=idx held; write f into tt[idx*NO +: NO]; if idx==(1<<NI)-1 go DONE, else idx+1, go APPLY.
REQ-016 DONE: done=1 for exactly one cycle, busy=0, x=0, then IDLE.
REQ-017 Start-to-done latency: done asserts exactly (1<<NI)*(SETTLE+1)+1 cycles after start is sampled in IDLE.
REQ-018 start SHALL be ignored in APPLY, SAMPLE and DONE; no queuing.
REQ-019 start held high continuously SHALL begin a new sweep on the first IDLE cycle after DONE.
REQ-020 tt SHALL hold its last value from DONE until the next accepted start.
REQ-021 idx SHALL be NI bits wide with no wrap past (1<<NI)-1 within a sweep.
REQ-022 Wait counter SHALL be 4 bits wide and saturate-free given the SETTLE range.

Reset
REQ-023 rst_n=0 at a clock edge SHALL force IDLE, idx=0, counter=0, x=0, busy=0, done=0, tt=0, sig=16'hFFFF, regardless of state.
REQ-024 Reset mid-sweep SHALL discard the partial sweep; no done pulse.

Configuration
REQ-025 Macro TT_MISR_EN defined: sig port exists; seeded 16'hFFFF on accepted start; in every SAMPLE cycle sig <= (sig<<1) ^ (sig[15] ? 16'h002D : 16'h0000) ^ zero-extended f; held otherwise.
REQ-026 Macro TT_MISR_EN undefined: no sig port, no MISR logic; all other behaviour identical.

Structure
REQ-027 Shared package tt_pkg SHALL hold the state enum typedef (IDLE/APPLY/SAMPLE/DONE), MISR polynomial 16'h002D and seed 16'hFFFF constants.
REQ-028 MISR SHALL be the sub-module tt_misr (clk, rst_n, seed, en, d, sig), instantiated only under TT_MISR_EN; rest stays flat.

Verification
REQ-029 Loopback f={x,x}, SETTLE=1, pulse start: done at cycle 17 after start; tt[i*6 +: 6]=={i[2:0],i[2:0]} for i=0..7.
REQ-030 SETTLE=0, f=6'h3F constant: done 9 cycles after start; tt=48'hFFFF_FFFF_FFFF.
REQ-031 Pulse start again at cycles 3 and 8 of a running sweep: no restart, single done, tt unchanged vs REQ-029.
REQ-032 Assert rst_n=0 during APPLY with idx=4: next cycle x=0, busy=0, tt=0; no done for 20 cycles.
REQ-033 start held high 40 cycles, SETTLE=1: done pulses at cycles 17 and 35 after first acceptance; busy low only on each DONE cycle and the IDLE cycle following it.
REQ-034 With TT_MISR_EN, loopback f={x,x}: sig after done equals cycle-accurate software model of REQ-025; with f=0, sig differs from 16'hFFFF.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table capture sequencer: FSM state type,
// MISR polynomial/seed constants and the single-step MISR update function.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h002D;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  // One MISR step: shift left, fold the polynomial back in on a carry-out,
  // then absorb the (already zero-extended) data word.
  function automatic logic [15:0] misr_step(input logic [15:0] cur,
                                            input logic [15:0] d);
    return {cur[14:0], 1'b0} ^ (cur[15] ? MISR_POLY : 16'h0000) ^ d;
  endfunction

endpackage

// File: rtl/tt_misr.sv
// 16-bit MISR compacting the sampled outputs of each sweep; a seed strobe
// reloads the start value, en advances one step.
module tt_misr
  import tt_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         seed,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [15:0]  sig
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig <= MISR_SEED;
    end else if (seed) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= misr_step(sig, 16'(d));
    end
  end

endmodule

// File: rtl/tt_capture_seq.sv
// Exhaustive truth-table capture: walks x through every input code, waits
// SETTLE cycles, samples f into tt. Optional MISR signature with TT_MISR_EN.
module tt_capture_seq
  import tt_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int NI     = 3,
  parameter int NO     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [NI-1:0]            x,
  input  logic [NO-1:0]            f,
  output logic [(1<<NI)*NO-1:0]    tt
`ifdef TT_MISR_EN
  ,
  output logic [15:0]              sig
`endif
);

  // With SETTLE=0 there is nothing to wait for, so APPLY is skipped entirely
  // and every code costs exactly one SAMPLE cycle.
  localparam state_t     FIRST    = (SETTLE == 0) ? SAMPLE : APPLY;
  localparam logic [3:0] CNT_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

  state_t          state;
  logic [NI-1:0]   idx;
  logic [3:0]      cnt;

  // NOTE: state is updated only with non-blocking assignments so every flop
  // sees the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      tt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tt    <= '0;
            idx   <= '0;
            cnt   <= '0;
            state <= FIRST;
          end
        end
        APPLY: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= SAMPLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SAMPLE: begin
          tt[int'(idx)*NO +: NO] <= f;
          if (idx == {NI{1'b1}}) begin
            state <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= FIRST;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == APPLY) || (state == SAMPLE);
  assign done = (state == DONE);
  assign x    = busy ? idx : '0;

`ifdef TT_MISR_EN
  logic misr_seed;
  logic misr_en;

  assign misr_seed = (state == IDLE) && start;
  assign misr_en   = (state == SAMPLE);

  tt_misr #(.W(NO)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (misr_seed),
    .en    (misr_en),
    .d     (f),
    .sig   (sig)
  );
`endif

endmodule

// File: tb/tb_tt_capture_seq.sv
// Bench for tt_capture_seq: three instances (SETTLE 1, 0, 3) against a
// sweep-timeline model, plus directed latency/abort/hold scenarios.
module tb_tt_capture_seq;

  localparam int ND = 3;
  localparam int N  = 8;
  localparam int NO = 6;
  localparam int TW = N * NO;
  localparam int SET [ND] = '{1, 0, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n_v [ND];
  logic          start_v [ND];
  logic          busy_v  [ND];
  logic          done_v  [ND];
  logic [2:0]    x_v     [ND];
  logic [5:0]    f_v     [ND];
  logic [TW-1:0] tt_v    [ND];
`ifdef TT_MISR_EN
  logic [15:0]   sig_v   [ND];
`endif

  // Upstream block stand-in: 0 = loopback {x,x}, 1 = constant, 2 = lookup table.
  int         mode [ND];
  logic [5:0] cval [ND];
  logic [5:0] lut  [ND][N];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [5:0] f_of(input int d, input logic [2:0] xx);
    case (mode[d])
      0:       return {xx, xx};
      1:       return cval[d];
      default: return lut[d][xx];
    endcase
  endfunction

  always_comb begin
    for (int d = 0; d < ND; d++) f_v[d] = f_of(d, x_v[d]);
  end

  tt_capture_seq #(.SETTLE(1), .NI(3), .NO(6)) u0 (
    .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .x(x_v[0]), .f(f_v[0]), .tt(tt_v[0])
`ifdef TT_MISR_EN
    , .sig(sig_v[0])
`endif
  );

  tt_capture_seq #(.SETTLE(0), .NI(3), .NO(6)) u1 (
    .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .x(x_v[1]), .f(f_v[1]), .tt(tt_v[1])
`ifdef TT_MISR_EN
    , .sig(sig_v[1])
`endif
  );

  tt_capture_seq #(.SETTLE(3), .NI(3), .NO(6)) u2 (
    .clk(clk), .rst_n(rst_n_v[2]), .start(start_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .x(x_v[2]), .f(f_v[2]), .tt(tt_v[2])
`ifdef TT_MISR_EN
    , .sig(sig_v[2])
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a sweep is a count t of cycles since acceptance. Each code
  // occupies SETTLE+1 cycles and is captured in the last of them; cycle
  // N*(SETTLE+1)+1 is the done cycle.
  bit            m_in  [ND];
  int            m_t   [ND];
  logic [TW-1:0] m_tt  [ND];
  logic [15:0]   m_sig [ND];

  initial begin
    for (int d = 0; d < ND; d++) begin
      m_in[d] = 0; m_t[d] = 0; m_tt[d] = '0; m_sig[d] = 16'hFFFF;
    end
  end

  always @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      int p;
      p = SET[d] + 1;
      if (!rst_n_v[d]) begin
        m_in[d] = 0; m_t[d] = 0; m_tt[d] = '0; m_sig[d] = 16'hFFFF;
      end else if (m_in[d]) begin
        if (m_t[d] == N * p + 1) begin
          m_in[d] = 0;
        end else begin
          if ((m_t[d] - 1) % p == SET[d]) begin
            int k;
            logic [5:0] fv;
            k  = (m_t[d] - 1) / p;
            fv = f_of(d, k[2:0]);
            m_tt[d][k*NO +: NO] = fv;
            m_sig[d] = {m_sig[d][14:0], 1'b0} ^ (m_sig[d][15] ? 16'h002D : 16'h0000)
                       ^ {10'b0, fv};
          end
          m_t[d]++;
        end
      end else if (start_v[d]) begin
        m_in[d] = 1; m_t[d] = 1; m_tt[d] = '0; m_sig[d] = 16'hFFFF;
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      int p;
      logic [2:0] ex;
      logic eb, ed;
      p  = SET[d] + 1;
      ex = '0; eb = 1'b0; ed = 1'b0;
      if (m_in[d] && m_t[d] <= N * p) begin
        int k;
        k  = (m_t[d] - 1) / p;
        ex = k[2:0];
        eb = 1'b1;
      end else if (m_in[d] && m_t[d] == N * p + 1) begin
        ed = 1'b1;
      end
      check($sformatf("u%0d_x", d),    64'(x_v[d]),    64'(ex));
      check($sformatf("u%0d_busy", d), 64'(busy_v[d]), 64'(eb));
      check($sformatf("u%0d_done", d), 64'(done_v[d]), 64'(ed));
      check($sformatf("u%0d_tt", d),   64'(tt_v[d]),   64'(m_tt[d]));
`ifdef TT_MISR_EN
      check($sformatf("u%0d_sig", d),  64'(sig_v[d]),  64'(m_sig[d]));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start high in cycle 0 (plus optional hold / extra pulses), then observe
  // cycles 1..cycles at the falling edge.
  task automatic run_window(input int d, input int cycles, input int hold,
                            input int p1, input int p2,
                            output int n_done, output int d1, output int d2,
                            output int n_busy_low);
    n_done = 0; d1 = -1; d2 = -1; n_busy_low = 0;
    start_v[d] = 1'b1;
    for (int c = 1; c <= cycles; c++) begin
      step();
      start_v[d] = (c < hold) || (c == p1) || (c == p2);
      @(negedge clk);
      if (done_v[d]) begin
        n_done++;
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
      if (!busy_v[d]) n_busy_low++;
    end
    start_v[d] = 1'b0;
  endtask

  logic [TW-1:0] loop_tt;
  int nd, c1, c2, bl;

  initial begin
    for (int d = 0; d < ND; d++) begin
      rst_n_v[d] = 1'b0; start_v[d] = 1'b0; mode[d] = 0; cval[d] = '0;
      for (int i = 0; i < N; i++) lut[d][i] = 6'($urandom);
    end
    for (int i = 0; i < N; i++) begin
      logic [2:0] i3;
      i3 = 3'(i);
      loop_tt[i*NO +: NO] = {i3, i3};
    end

    repeat (2) step();
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check("reset_x",    64'(x_v[d]),    64'd0);
      check("reset_busy", 64'(busy_v[d]), 64'd0);
      check("reset_done", 64'(done_v[d]), 64'd0);
      check("reset_tt",   64'(tt_v[d]),   64'd0);
`ifdef TT_MISR_EN
      check("reset_sig",  64'(sig_v[d]),  64'hFFFF);
`endif
    end
    step();
    for (int d = 0; d < ND; d++) rst_n_v[d] = 1'b1;
    step();

    // Loopback sweep, SETTLE=1.
    run_window(0, 20, 1, -1, -1, nd, c1, c2, bl);
    check("loop_done_count", 64'(nd), 64'd1);
    check("loop_latency",    64'(c1), 64'd17);
    check("loop_tt",         64'(tt_v[0]), 64'(loop_tt));
`ifdef TT_MISR_EN
    check("loop_sig_model",  64'(sig_v[0]), 64'(m_sig[0]));
`endif

    // Extra start pulses mid-sweep are ignored.
    step();
    run_window(0, 25, 1, 3, 8, nd, c1, c2, bl);
    check("ignore_done_count", 64'(nd), 64'd1);
    check("ignore_latency",    64'(c1), 64'd17);
    check("ignore_tt",         64'(tt_v[0]), 64'(loop_tt));

    // SETTLE=0, constant all-ones.
    step();
    mode[1] = 1; cval[1] = 6'h3F;
    run_window(1, 12, 1, -1, -1, nd, c1, c2, bl);
    check("s0_done_count", 64'(nd), 64'd1);
    check("s0_latency",    64'(c1), 64'd9);
    check("s0_tt",         64'(tt_v[1]), 64'hFFFF_FFFF_FFFF);

`ifdef TT_MISR_EN
    // Eight steps of all-zero data from the seed.
    step();
    cval[1] = 6'h00;
    run_window(1, 12, 1, -1, -1, nd, c1, c2, bl);
    check("misr_f0_differs", 64'(sig_v[1] != 16'hFFFF), 64'd1);
    check("misr_f0_value",   64'(sig_v[1]), 64'hE41B);
`endif

    // SETTLE=3 loopback.
    step();
    run_window(2, 36, 1, -1, -1, nd, c1, c2, bl);
    check("s3_latency", 64'(c1), 64'd33);
    check("s3_tt",      64'(tt_v[2]), 64'(loop_tt));

    // start held high: back-to-back sweeps.
    step();
    run_window(0, 40, 40, -1, -1, nd, c1, c2, bl);
    check("hold_done_count", 64'(nd), 64'd2);
    check("hold_first",      64'(c1), 64'd17);
    check("hold_second",     64'(c2), 64'd35);
    check("hold_busy_low",   64'(bl), 64'd4);
    repeat (40) step();

    // Reset while applying code 4 (cycle 9 with SETTLE=1).
    start_v[0] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      start_v[0] = 1'b0;
    end
    rst_n_v[0] = 1'b0;
    @(negedge clk);
    check("abort_pre_x",    64'(x_v[0]),    64'd4);
    check("abort_pre_busy", 64'(busy_v[0]), 64'd1);
    step();
    rst_n_v[0] = 1'b1;
    @(negedge clk);
    check("abort_x",    64'(x_v[0]),    64'd0);
    check("abort_busy", 64'(busy_v[0]), 64'd0);
    check("abort_tt",   64'(tt_v[0]),   64'd0);
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      @(negedge clk);
      if (done_v[0]) nd++;
    end
    check("abort_no_done", 64'(nd), 64'd0);

    // Randomized traffic on all instances.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int d = 0; d < ND; d++) begin
        start_v[d] = ($urandom % 4) == 0;
        rst_n_v[d] = ($urandom % 64) != 0;
        if (($urandom % 16) == 0) mode[d] = int'($urandom % 3);
        if (($urandom % 16) == 0) cval[d] = 6'($urandom);
        if (($urandom % 8) == 0)  lut[d][$urandom % N] = 6'($urandom);
      end
    end

    step();
    for (int d = 0; d < ND; d++) begin
      start_v[d] = 1'b0; rst_n_v[d] = 1'b1;
    end
    repeat (50) step();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
